imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the core's fetch interface (imem_req_addr / imem_req_val in, imem_resp_data out).
- Word-organised instruction store with a fixed, parameterised read latency, a kill input for redirects, and a testrig load port for preloading programs before the core runs.
- Sits between the chronos fetch stage and the testbench/loader.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the store; power of two, 16..65536.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_addr  in  32  fetch byte address.
- imem_req_val  in  1  fetch request valid.
- imem_req_rdy  out  1  responder can accept a request this cycle.
- imem_req_kill  in  1  drop all in-flight responses (branch redirect).
- imem_resp_data  out  32  instruction word.
- imem_resp_val  out  1  imem_resp_data is a valid response.
- imem_resp_err  out  1  accompanies resp_val; request was misaligned or out of range.
- ld_val  in  1  loader write strobe.
- ld_addr  in  32  loader byte address, word aligned.
- ld_data  in  32  loader write data.
- fetch_count  out  32  count of delivered valid responses, saturating.

Behaviour:
- Reset (rst=0, async): resp_val=0, resp_err=0, resp_data=INST_NOP (32'h0000_0013), fetch_count=0, all pipeline valids cleared. Storage array is not reset. In-flight requests are lost. req_rdy=0 while rst=0.
- Accept: a request is accepted on a posedge when imem_req_val=1 and imem_req_rdy=1.
- Ready: imem_req_rdy = rst & ~ld_val.
  - The loader has priority; a request presented while ld_val=1 is not accepted and is not queued.
  - The requester must hold or re-present it.
- Index: word index = (addr - BASE_ADDR) >> 2.
- Error: err = (addr[1:0] != 0) | (addr - BASE_ADDR >= DEPTH_WORDS*4), using unsigned 32-bit compare. Wrap-around below BASE_ADDR therefore counts as out of range.
- Erroring requests return data INST_NOP with err=1. The array is not read.
- Latency: a request accepted at edge N produces resp_val=1 with its data and err during the cycle after edge N+LATENCY-1.
  - LATENCY=1: response is visible in the cycle following acceptance.
  - Fully pipelined: one request per cycle; responses return in order.
- Kill: imem_req_kill=1 at an edge clears every in-flight pipeline valid, including the stage that would present on the next cycle.
  - A request accepted at the same edge as kill is retained: new request wins, older ones are dropped.
  - A response already presented this cycle is unaffected.
- Idle: when resp_val=0, resp_data=INST_NOP and resp_err=0.
- Load: ld_val=1 writes ld_data to word (ld_addr-BASE_ADDR)>>2 at the edge.
  - Out-of-range or misaligned ld_addr: the write is silently dropped.
  - Read-during-write ordering: a request accepted after the load edge sees the new data. Requests already in flight return old data.
- fetch_count: increments by 1 for each cycle with resp_val=1, errors included. Holds at 32'hFFFF_FFFF.

Decomposition:
- Shared defines.vh: INST_NOP, the LATENCY bounds, and the loader/error encodings if ever extended.
- One sub-module, imem_resp_pipe, a LATENCY-deep shift of {valid, err, data} with async reset and synchronous kill clear.
- The top holds the array, address check, ready logic and counter.

Test Plan:
- Basic fetch:
  - Load 0x100 words with data = 0xA000_0000+i; then LATENCY=1, request 0x0,0x4,0x8 back-to-back.
  - Expect resp_val on three consecutive cycles with A0000000, A0000001, A0000002; fetch_count=3.
- LATENCY=3 streaming:
  - Accept requests at cycles 0..4.
  - Expect the first resp_val in the cycle after edge 2, five contiguous in-order responses, none dropped.
- Kill:
  - LATENCY=3; requests at cycles 0,1,2; kill asserted at the edge of cycle 2 together with a request to 0x40.
  - Expect only the 0x40 response; fetch_count increments by 1.
- Errors:
  - Request 0x2 → err=1, data 0x0000_0013.
  - Request DEPTH_WORDS*4 → err=1.
  - Request 0xFFFF_FFFC with BASE_ADDR=0x1000 → err=1.
- Loader priority:
  - ld_val=1 for 2 cycles while req_val=1 → req_rdy=0 and no responses.
  - The request accepted after the load returns the newly loaded word.
- Async reset mid-stream:
  - LATENCY=2; drop rst between edges with a response pending.
  - Expect resp_val=0 and resp_data=0x0000_0013 immediately; no response after release; fetch_count=0; array contents retained.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared constants, response record and address check for imem_responder
package imem_responder_pkg;

  // Instruction returned for idle cycles and for erroring requests (addi x0,x0,0).
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Legal bounds of the response latency parameter.
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // One response slot travelling down the latency pipe.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  // True when a byte address is misaligned or falls outside [base, base+span).
  // The offset is an unsigned 32-bit difference, so addresses below base wrap
  // to a huge offset and are reported as out of range.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] span_bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (off >= span_bytes);
  endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// rtl/imem_resp_pipe.sv - LATENCY-deep response shift register with kill
module imem_resp_pipe
  import imem_responder_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  kill_i,
  input  resp_t in_i,
  output resp_t out_o
);

  resp_t [LATENCY-1:0] stage_q;
  resp_t [LATENCY-1:0] stage_d;

  // Stage 0 always takes the new request so a request accepted together with
  // kill survives; every older stage loses its valid on kill.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in_i;
    for (int k = 1; k < LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
      if (kill_i) begin
        stage_d[k].valid = 1'b0;
      end
    end
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= '{valid: 1'b0, err: 1'b0, data: INST_NOP};
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder with loader port and fixed read latency
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_req_addr,
  input  logic        imem_req_val,
  output logic        imem_req_rdy,
  input  logic        imem_req_kill,
  output logic [31:0] imem_resp_data,
  output logic        imem_resp_val,
  output logic        imem_resp_err,
  input  logic        ld_val,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] fetch_count
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) * 32'd4;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req_accept;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          ld_ok;
  logic [AW-1:0] ld_idx;
  resp_t         pipe_in;
  resp_t         pipe_out;
  logic [31:0]   fetch_count_q;
  logic [31:0]   fetch_count_d;

  // The loader owns the array while ld_val is high, so a read and a write
  // never share an edge and a later fetch always sees the loaded word.
  assign imem_req_rdy = rst & ~ld_val;
  assign req_accept   = imem_req_val & imem_req_rdy;

  assign req_err = addr_bad(imem_req_addr, BASE_ADDR, SPAN);
  assign req_idx = AW'((imem_req_addr - BASE_ADDR) >> 2);
  assign ld_ok   = ~addr_bad(ld_addr, BASE_ADDR, SPAN);
  assign ld_idx  = AW'((ld_addr - BASE_ADDR) >> 2);

  // Instruction store; deliberately not reset so programs survive a core reset.
  always_ff @(posedge clk) begin
    if (ld_val && ld_ok) begin
      mem_q[ld_idx] <= ld_data;
    end
  end

  // Erroring requests carry a NOP instead of touching the array.
  always_comb begin
    pipe_in.valid = req_accept;
    pipe_in.err   = req_err;
    pipe_in.data  = req_err ? INST_NOP : mem_q[req_idx];
  end

  imem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk_i  (clk),
    .rst_ni (rst),
    .kill_i (imem_req_kill),
    .in_i   (pipe_in),
    .out_o  (pipe_out)
  );

  assign imem_resp_val  = pipe_out.valid;
  assign imem_resp_err  = pipe_out.valid & pipe_out.err;
  assign imem_resp_data = pipe_out.valid ? pipe_out.data : INST_NOP;

  // Count each presented response, saturating at all ones.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (imem_resp_val && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // Delivered-response counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder across three configurations
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] req_addr;
  logic        req_val;
  logic        req_kill;
  logic        ld_val;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  logic        rdy [3];
  logic        rv  [3];
  logic        re  [3];
  logic [31:0] rd  [3];
  logic [31:0] fc  [3];

  // A: LATENCY 1 at 0; B: LATENCY 3 at 0x1000; C: LATENCY 2 at 0, small store.
  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .imem_req_addr(req_addr), .imem_req_val(req_val),
    .imem_req_rdy(rdy[0]), .imem_req_kill(req_kill), .imem_resp_data(rd[0]),
    .imem_resp_val(rv[0]), .imem_resp_err(re[0]), .ld_val(ld_val), .ld_addr(ld_addr),
    .ld_data(ld_data), .fetch_count(fc[0]));

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(3), .BASE_ADDR(32'h0000_1000)) dut_b (
    .clk(clk), .rst(rst), .imem_req_addr(req_addr), .imem_req_val(req_val),
    .imem_req_rdy(rdy[1]), .imem_req_kill(req_kill), .imem_resp_data(rd[1]),
    .imem_resp_val(rv[1]), .imem_resp_err(re[1]), .ld_val(ld_val), .ld_addr(ld_addr),
    .ld_data(ld_data), .fetch_count(fc[1]));

  imem_responder #(.DEPTH_WORDS(64), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut_c (
    .clk(clk), .rst(rst), .imem_req_addr(req_addr), .imem_req_val(req_val),
    .imem_req_rdy(rdy[2]), .imem_req_kill(req_kill), .imem_resp_data(rd[2]),
    .imem_resp_val(rv[2]), .imem_resp_err(re[2]), .ld_val(ld_val), .ld_addr(ld_addr),
    .ld_data(ld_data), .fetch_count(fc[2]));

  int ncomp = 0;
  int nfail = 0;
  int cyc   = 0;

  int          lat_v   [3];
  logic [31:0] base_v  [3];
  int          depth_v [3];

  // Reference model: word store per configuration plus a queue of promised
  // responses, each tagged with the cycle in which it must appear.
  logic [31:0] mm     [3][1024];
  int          q_due  [3][8];
  logic [31:0] q_data [3][8];
  logic        q_err  [3][8];
  int          q_head [3];
  int          q_tail [3];
  int          exp_cnt[3];
  int          pulses [3];

  function automatic logic bad_addr(input logic [31:0] a, input int i);
    logic [31:0] off;
    off = a - base_v[i];
    return (a[1:0] != 2'b00) || (off >= 32'(depth_v[i] * 4));
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 32'h14FF / 4)) << 2;
    else if (r == 7) return (32'($urandom_range(0, 32'h13FF))) | 32'($urandom_range(1, 3));
    else if (r == 8) return 32'hFFFF_FFFC;
    else             return $urandom;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        if (ld_val && !bad_addr(ld_addr, i)) mm[i][(ld_addr - base_v[i]) >> 2] = ld_data;
        if (req_kill) q_head[i] = q_tail[i];
        if (req_val && !ld_val) begin
          q_due[i][q_tail[i] % 8] = cyc + lat_v[i] - 1;
          q_err[i][q_tail[i] % 8] = bad_addr(req_addr, i);
          if (bad_addr(req_addr, i)) q_data[i][q_tail[i] % 8] = NOP;
          else                       q_data[i][q_tail[i] % 8] = mm[i][(req_addr - base_v[i]) >> 2];
          q_tail[i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic        ev;
      logic [31:0] ed;
      logic        ee;
      ev = (q_head[i] != q_tail[i]) && (q_due[i][q_head[i] % 8] == cyc);
      ed = ev ? q_data[i][q_head[i] % 8] : NOP;
      ee = ev ? q_err[i][q_head[i] % 8] : 1'b0;
      chk("req_rdy", i, 32'(rdy[i]), 32'(rst & ~ld_val));
      chk("resp_val", i, 32'(rv[i]), 32'(ev));
      chk("resp_data", i, rd[i], ed);
      chk("resp_err", i, 32'(re[i]), 32'(ee));
      chk("fetch_count", i, fc[i], 32'(exp_cnt[i]));
      if (ev) begin
        q_head[i]++;
        exp_cnt[i]++;
      end
      if (rv[i] === 1'b1) pulses[i]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic req(input logic [31:0] a);
    req_addr = a;
    req_val  = 1'b1;
    tick();
    req_val  = 1'b0;
  endtask

  task automatic idle(input int n);
    req_val  = 1'b0;
    req_kill = 1'b0;
    ld_val   = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    lat_v   = '{1, 3, 2};
    base_v  = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
    depth_v = '{1024, 256, 64};
    for (int i = 0; i < 3; i++) begin
      q_head[i] = 0; q_tail[i] = 0; exp_cnt[i] = 0; pulses[i] = 0;
    end
    rst = 1'b0; req_addr = '0; req_val = 1'b0; req_kill = 1'b0;
    ld_val = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state.
    idle(2);
    rst = 1'b1;
    idle(1);

    // Preload every in-range word of all three stores.
    for (int a = 0; a < 32'h1400; a += 4) begin
      ld_val  = 1'b1;
      ld_addr = 32'(a);
      ld_data = 32'hA000_0000 + 32'(a >> 2);
      tick();
    end
    idle(2);

    // Basic fetch, back to back.
    req(32'h0);
    chk("basic_d0", 0, rd[0], 32'hA000_0000);
    req(32'h4);
    chk("basic_d1", 0, rd[0], 32'hA000_0001);
    req(32'h8);
    chk("basic_d2", 0, rd[0], 32'hA000_0002);
    idle(3);
    chk("basic_count", 0, fc[0], 32'd3);

    // Streaming five requests through the 3-deep pipe.
    pulses[1] = 0;
    for (int k = 0; k < 5; k++) req(32'h1000 + 32'(k * 4));
    idle(5);
    chk("stream_count", 1, 32'(pulses[1]), 32'd5);

    // Kill together with a new request: only the new one returns.
    pulses[1] = 0;
    req(32'h1000);
    req(32'h1004);
    req_kill = 1'b1;
    req(32'h1040);
    req_kill = 1'b0;
    idle(5);
    chk("kill_count", 1, 32'(pulses[1]), 32'd1);

    // Error cases.
    req(32'h2);
    chk("err_misaligned_err", 0, 32'(re[0]), 32'd1);
    chk("err_misaligned_data", 0, rd[0], NOP);
    req(32'h1000);
    chk("err_range_err", 0, 32'(re[0]), 32'd1);
    req(32'hFFFF_FFFC);
    idle(4);

    // Loader priority over fetch.
    pulses[0] = 0;
    req_val = 1'b1; req_addr = 32'h10;
    ld_val = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_addr = 32'h14; ld_data = 32'h1234_5678;
    tick();
    ld_val = 1'b0;
    chk("ld_no_resp", 0, 32'(pulses[0]), 32'd0);
    req(32'h10);
    chk("ld_new_data0", 0, rd[0], 32'hDEAD_BEEF);
    req(32'h14);
    chk("ld_new_data1", 0, rd[0], 32'h1234_5678);
    idle(4);

    // Asynchronous reset between edges with responses pending.
    req(32'h20);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_val", i, 32'(rv[i]), 32'd0);
      chk("rst_data", i, rd[i], NOP);
      chk("rst_err", i, 32'(re[i]), 32'd0);
      chk("rst_count", i, fc[i], 32'd0);
      q_head[i] = q_tail[i];
      exp_cnt[i] = 0;
    end
    idle(2);
    rst = 1'b1;
    pulses[2] = 0;
    idle(4);
    chk("rst_no_resp", 2, 32'(pulses[2]), 32'd0);
    req(32'h20);
    idle(1);
    chk("retain", 2, rd[2], 32'hA000_0008);
    idle(3);

    // Randomised traffic with kills and interleaved loads.
    for (int n = 0; n < 400; n++) begin
      req_val  = ($urandom_range(0, 3) != 0);
      req_addr = rnd_addr();
      req_kill = ($urandom_range(0, 9) == 0);
      ld_val   = ($urandom_range(0, 7) == 0);
      ld_addr  = ($urandom_range(0, 9) == 0) ? rnd_addr() : (32'($urandom_range(0, 32'h13FF / 4)) << 2);
      ld_data  = $urandom;
      tick();
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
